// File: rtl/fw_ip_cfg_shift.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fw_ip_cfg_shift : SW-buffered serial config-chain shifter with readback. Rev 1.0
// ---------------------------------------------------------------------------
module fw_ip_cfg_shift #(
  parameter int CFG_BITS = 96,
  parameter int CLK_DIV  = 4,
  parameter int LOAD_W   = 4,
  parameter int RST_W    = 8
) (
  input  logic        fw_clk,
  input  logic        fw_rst_n,
  input  logic        fw_dev_id_enable,
  input  logic        fw_op_code_w_reset,
  input  logic        fw_op_code_w_cfg_static_0,
  input  logic        fw_op_code_r_cfg_static_0,
  input  logic        fw_op_code_w_status_clear,
  input  logic        fw_op_code_w_execute,
  input  logic [23:0] sw_write24_0,
  output logic [31:0] fw_read_data32,
  output logic [31:0] fw_read_status32,
  output logic        fw_config_clk,
  output logic        fw_config_in,
  output logic        fw_config_load,
  output logic        fw_reset_not,
  input  logic        fw_config_out
);
  localparam int NUM_WORDS = CFG_BITS / 24;
  localparam int PTR_W     = 8;
  localparam int IDX_W     = $clog2(CFG_BITS);
  localparam int PH_MAX    = (CLK_DIV > LOAD_W) ? CLK_DIV : LOAD_W;
  localparam int PH_W      = $clog2(PH_MAX + 1);
  localparam int RC_W      = $clog2(RST_W + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LOAD     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CFG_BITS-1:0] wr_buf, rb_buf, rb_sr;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [IDX_W-1:0]    bit_cnt;
  logic [PH_W-1:0]     phase;
  logic [RC_W-1:0]     rst_cnt;
  logic                done, error;

  logic op_rst, op_exec, op_wcfg, op_rcfg, op_clr;
  logic phase_last, shifting, set_err, set_done;
  logic [IDX_W-1:0] wr_base, rd_base;

  assign op_rst  = fw_dev_id_enable & fw_op_code_w_reset;
  assign op_exec = fw_dev_id_enable & fw_op_code_w_execute;
  assign op_wcfg = fw_dev_id_enable & fw_op_code_w_cfg_static_0;
  assign op_rcfg = fw_dev_id_enable & fw_op_code_r_cfg_static_0;
  assign op_clr  = fw_dev_id_enable & fw_op_code_w_status_clear;

  assign wr_base  = IDX_W'(32'(wr_ptr) * 24);
  assign rd_base  = IDX_W'(32'(rd_ptr) * 24);
  assign shifting = (state == SHIFT_LO) || (state == SHIFT_HI);

  // Ops that would disturb the chain while a transfer runs are flagged, not obeyed.
  assign set_err  = (op_exec | op_wcfg) & (state != IDLE) & ~op_rst;
  assign set_done = (state == DONE) & ~op_rst;

  always_comb begin
    phase_last = 1'b0;
    if (shifting)           phase_last = (phase == PH_W'(CLK_DIV - 1));
    else if (state == LOAD) phase_last = (phase == PH_W'(LOAD_W - 1));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (op_exec) state_nxt = SHIFT_LO;
      SHIFT_LO: if (phase_last) state_nxt = SHIFT_HI;
      SHIFT_HI: if (phase_last) state_nxt = (bit_cnt == '0) ? LOAD : SHIFT_LO;
      LOAD:     if (phase_last) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (op_rst) state_nxt = IDLE;
  end

  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state          <= IDLE;
      phase          <= '0;
      bit_cnt        <= '0;
      rst_cnt        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      wr_buf         <= '0;
      rb_buf         <= '0;
      rb_sr          <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      fw_read_data32 <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || (state == IDLE) || (state == DONE)) phase <= '0;
      else                                                             phase <= phase + 1'b1;

      if (state == IDLE && op_exec && !op_rst) begin
        bit_cnt <= IDX_W'(CFG_BITS - 1);
        rb_sr   <= '0;
      end else if (state == SHIFT_HI && phase_last && bit_cnt != '0) begin
        bit_cnt <= bit_cnt - 1'b1;
      end

      // Return bit is captured once per bit, at the first high-phase cycle.
      if (state == SHIFT_HI && phase == '0) rb_sr <= {rb_sr[CFG_BITS-2:0], fw_config_out};
      if (state == LOAD && phase_last && !op_rst) rb_buf <= rb_sr;

      if (op_rcfg) begin
        fw_read_data32 <= {8'h00, rb_buf[rd_base +: 24]};
        rd_ptr <= (rd_ptr == PTR_W'(NUM_WORDS - 1)) ? '0 : rd_ptr + 1'b1;
      end

      if (op_rst) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        rst_cnt <= RC_W'(RST_W);
      end else begin
        if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
        if (state == IDLE && op_wcfg && !op_exec) begin
          wr_buf[wr_base +: 24] <= sw_write24_0;
          wr_ptr <= (wr_ptr == PTR_W'(NUM_WORDS - 1)) ? '0 : wr_ptr + 1'b1;
        end
      end

      error <= set_err  | (error & ~op_clr);
      done  <= set_done | (done  & ~op_clr);
    end
  end

  assign fw_config_clk    = (state == SHIFT_HI);
  assign fw_config_in     = shifting & wr_buf[bit_cnt];
  assign fw_config_load   = ~shifting;
  assign fw_reset_not     = (rst_cnt == '0);
  assign fw_read_status32 = {8'h04, rd_ptr, wr_ptr, 5'b0, error, done, (state != IDLE)};

endmodule
`default_nettype wire

// File: tb/tb_fw_ip_cfg_shift.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fw_ip_cfg_shift : transaction-level model bench for fw_ip_cfg_shift. Rev 1.0
// ---------------------------------------------------------------------------
module tb_fw_ip_cfg_shift;
  localparam int CFG_BITS = 48;
  localparam int CLK_DIV  = 2;
  localparam int LOAD_W   = 3;
  localparam int RST_W    = 4;
  localparam int NW       = CFG_BITS / 24;
  localparam int T_SH     = CFG_BITS * 2 * CLK_DIV;
  localparam int T_DONE   = T_SH + LOAD_W + 1;

  logic        clk, rst_n, en;
  logic        op_rst, op_wc, op_rc, op_clr, op_ex;
  logic [23:0] wdata;
  logic [31:0] rdata, status;
  logic        cfg_clk, cfg_in, cfg_load, reset_not, cfg_out;
  logic        loopback, rnd_out;

  int checks = 0;
  int failures = 0;

  assign cfg_out = loopback ? cfg_in : rnd_out;

  fw_ip_cfg_shift #(.CFG_BITS(CFG_BITS), .CLK_DIV(CLK_DIV), .LOAD_W(LOAD_W), .RST_W(RST_W)) dut (
    .fw_clk                   (clk),
    .fw_rst_n                 (rst_n),
    .fw_dev_id_enable         (en),
    .fw_op_code_w_reset       (op_rst),
    .fw_op_code_w_cfg_static_0(op_wc),
    .fw_op_code_r_cfg_static_0(op_rc),
    .fw_op_code_w_status_clear(op_clr),
    .fw_op_code_w_execute     (op_ex),
    .sw_write24_0             (wdata),
    .fw_read_data32           (rdata),
    .fw_read_status32         (status),
    .fw_config_clk            (cfg_clk),
    .fw_config_in             (cfg_in),
    .fw_config_load           (cfg_load),
    .fw_reset_not             (reset_not),
    .fw_config_out            (cfg_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: c = cycle index within a transfer (0 = idle), buffers as flat chains.
  int                  c, rst_left;
  bit [7:0]            wp, rp;
  bit                  err, dn;
  bit [31:0]           exp_rd;
  bit [CFG_BITS-1:0]   wr_chain, rb_chain, cap;

  function automatic bit m_shifting();
    return (c >= 1) && (c <= T_SH);
  endfunction

  function automatic bit e_in();
    int k;
    if (!m_shifting()) return 1'b0;
    k = CFG_BITS - 1 - (c - 1) / (2 * CLK_DIV);
    return 1'(wr_chain >> k);
  endfunction

  function automatic bit e_clk();
    return m_shifting() && (((c - 1) % (2 * CLK_DIV)) >= CLK_DIV);
  endfunction

  function automatic logic [31:0] e_status();
    return {8'h04, rp, wp, 5'b0, err, dn, (c != 0)};
  endfunction

  task automatic model_reset();
    c = 0; rst_left = 0; wp = 0; rp = 0; err = 0; dn = 0;
    exp_rd = 0; wr_chain = '0; rb_chain = '0; cap = '0;
  endtask

  task automatic model_step();
    bit ex, wc, rc, cl, rs, busy, s_err, s_dn, b;
    int k;
    ex = en & op_ex; wc = en & op_wc; rc = en & op_rc; cl = en & op_clr; rs = en & op_rst;
    busy = (c != 0); s_err = 0; s_dn = 0;
    if (rc) begin
      exp_rd = {8'h00, 24'(rb_chain >> (int'(rp) * 24))};
      rp = (rp == 8'(NW - 1)) ? 8'd0 : rp + 8'd1;
    end
    if (rs) begin
      c = 0; wp = 0; rp = 0; rst_left = RST_W;
    end else begin
      if (rst_left > 0) rst_left--;
      s_err = (ex || wc) && busy;
      if (m_shifting() && ((c - 1) % (2 * CLK_DIV)) == CLK_DIV) begin
        k = CFG_BITS - 1 - (c - 1) / (2 * CLK_DIV);
        b = loopback ? e_in() : rnd_out;
        cap = cap | (CFG_BITS'(b) << k);
      end
      if (c == T_SH + LOAD_W) rb_chain = cap;
      s_dn = (c == T_DONE);
      if (busy) c = (c == T_DONE) ? 0 : c + 1;
      else if (ex) begin c = 1; cap = '0; end
      else if (wc) begin
        wr_chain = (wr_chain & ~(CFG_BITS'(24'hFFFFFF) << (int'(wp) * 24)))
                 | (CFG_BITS'(wdata) << (int'(wp) * 24));
        wp = (wp == 8'(NW - 1)) ? 8'd0 : wp + 8'd1;
      end
    end
    err = s_err ? 1'b1 : (cl ? 1'b0 : err);
    dn  = s_dn  ? 1'b1 : (cl ? 1'b0 : dn);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("cfg_clk",   32'(cfg_clk),   32'(e_clk()));
    chk("cfg_in",    32'(cfg_in),    32'(e_in()));
    chk("cfg_load",  32'(cfg_load),  32'(!m_shifting()));
    chk("reset_not", 32'(reset_not), 32'(rst_left == 0));
    chk("status",    status,         e_status());
    chk("rdata",     rdata,          exp_rd);
  endtask

  initial begin
    #1;
    forever begin
      @(negedge clk);
      compare();
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    op_rst = 0; op_wc = 0; op_rc = 0; op_clr = 0; op_ex = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic write(input logic [23:0] d);
    op_wc = 1; wdata = d; step();
  endtask

  task automatic read_chk(input string name, input logic [31:0] exp);
    op_rc = 1; step();
    chk(name, rdata, exp);
  endtask

  initial begin
    int rises, busy_cnt, low_cnt;
    logic prev_clk, first_in;
    rst_n = 0; en = 1; op_rst = 0; op_wc = 0; op_rc = 0; op_clr = 0; op_ex = 0;
    wdata = 0; loopback = 1; rnd_out = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_status", status, 32'h0400_0000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_outs", {28'h0, cfg_clk, cfg_in, cfg_load, reset_not}, 32'h3);

    // Loopback transfer of two words.
    write(24'hABCDEF);
    write(24'h123456);
    op_ex = 1; step();
    rises = 0; busy_cnt = 0; prev_clk = 0; first_in = cfg_in;
    for (int i = 0; i < 250; i++) begin
      if (cfg_clk && !prev_clk) rises++;
      prev_clk = cfg_clk;
      if (status[0]) busy_cnt++;
      step();
    end
    chk("first_bit", 32'(first_in), 32'h0);
    chk("clk_rises", 32'(rises), 32'd48);
    chk("busy_cycles", 32'(busy_cnt), 32'd196);
    chk("done_flag", 32'(status[1]), 32'h1);
    read_chk("rd_word0", 32'h00AB_CDEF);
    read_chk("rd_word1", 32'h0012_3456);

    // Write pointer wrap.
    write(24'h111111);
    write(24'h222222);
    write(24'h333333);
    chk("wrap_wp", 32'(status[15:8]), 32'h1);
    op_ex = 1; step();
    idle(200);
    read_chk("wrap_rd0", 32'h0033_3333);
    read_chk("wrap_rd1", 32'h0022_2222);

    // Execute while in the high phase of the first bit.
    op_clr = 1; step();
    op_ex = 1; step();
    idle(2);
    chk("in_shift_hi", 32'(cfg_clk), 32'h1);
    op_ex = 1; step();
    chk("busy_err", 32'(status[2]), 32'h1);
    idle(200);
    read_chk("err_rd0", 32'h0033_3333);
    read_chk("err_rd1", 32'h0022_2222);
    op_clr = 1; step();
    chk("clr_status", 32'(status[2:0]), 32'h0);

    // Soft reset 50 cycles into a transfer.
    write(24'hAAAAAA);
    write(24'h555555);
    op_ex = 1; step();
    idle(49);
    op_rst = 1; step();
    chk("srst_outs", {29'h0, cfg_load, cfg_clk, status[0]}, 32'h4);
    low_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (!reset_not) low_cnt++;
      step();
    end
    chk("srst_width", 32'(low_cnt), 32'd4);
    read_chk("srst_rd0", 32'h0033_3333);
    read_chk("srst_rd1", 32'h0022_2222);

    // Disabled device ignores execute.
    en = 0; op_ex = 1; step();
    en = 1;
    idle(3);
    chk("dis_status", status, 32'h0400_0000);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      en     = ($urandom % 8) != 0;
      op_rst = ($urandom % 250) == 0;
      op_ex  = ($urandom % 15) == 0;
      op_wc  = ($urandom % 5) == 0;
      op_rc  = ($urandom % 5) == 0;
      op_clr = ($urandom % 10) == 0;
      wdata  = 24'($urandom);
      rnd_out = 1'($urandom);
      if (($urandom % 50) == 0) loopback = ~loopback;
      step();
    end

    // Asynchronous reset in the middle of a transfer.
    en = 1; loopback = 1;
    op_rst = 1; step();
    idle(6);
    op_ex = 1; step();
    idle(20);
    #3 rst_n = 0;
    model_reset();
    #1;
    chk("arst_outs", {28'h0, cfg_clk, cfg_in, cfg_load, reset_not}, 32'h3);
    chk("arst_status", status, 32'h0400_0000);
    chk("arst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 rst_n = 1;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
